// File: rtl/onchip_dp_memory_if.sv
// Avalon-MM port bundle for onchip_dp_memory; instantiate once per port.
interface onchip_dp_memory_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic                    waitrequest;
    logic                    range_err;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
        input  readdata, readdatavalid, waitrequest, range_err
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
        output readdata, readdatavalid, waitrequest, range_err
    );
endinterface

// File: rtl/onchip_dp_memory.sv
// Dual-port on-chip RAM with two Avalon-MM slaves, pipelined reads and
// deterministic same-address write arbitration (s1 first, s2 one cycle later).
module onchip_dp_memory #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 12,
    parameter int    DEPTH        = 2500,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "onchip_dp_memory.hex"
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clken,
    input  logic              reset_req,
    onchip_dp_memory_if.slave s1,
    onchip_dp_memory_if.slave s2
);
    localparam int          NUM_BYTES = DATA_WIDTH / 8;
    localparam int          NUM_PORTS = 2;
    localparam int          MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);

    typedef logic [DATA_WIDTH-1:0] word_t;

    (* ram_init_file = INIT_FILE *) word_t mem [DEPTH];

    logic                                 en;
    logic                                 collision;
    logic [NUM_PORTS-1:0]                 req;
    logic [NUM_PORTS-1:0]                 is_wr;
    logic [NUM_PORTS-1:0]                 in_range;
    logic [NUM_PORTS-1:0]                 accept;
    logic [NUM_PORTS-1:0]                 rd_acc;
    logic [NUM_PORTS-1:0]                 wr_acc;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr;
    logic [NUM_PORTS-1:0][NUM_BYTES-1:0]  be;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata;

    logic                                 s2_prio_q;
    logic [NUM_PORTS-1:0]                 range_err_q, range_err_d;
    logic [NUM_PORTS-1:0]                 vld1_q;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata1_q;
    logic [NUM_PORTS-1:0]                 vld_out;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_out;

    assign en    = clken & ~reset_req;
    assign addr  = {s2.address, s1.address};
    assign be    = {s2.byteenable, s1.byteenable};
    assign wdata = {s2.writedata, s1.writedata};
    assign req   = {s2.chipselect & (s2.read | s2.write),
                    s1.chipselect & (s1.read | s1.write)};
    assign is_wr = {s2.write, s1.write};

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        in_range = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            in_range[p] = (32'(addr[p]) < DEPTH_W);
        end
    end

    // s2 loses a same-address write race once; the cycle after a stall it has priority.
    assign collision = en & req[0] & is_wr[0] & req[1] & is_wr[1]
                     & (addr[0] == addr[1]) & in_range[0] & ~s2_prio_q;

    assign s1.waitrequest = ~en;
    assign s2.waitrequest = ~en | collision;

    assign accept      = {req[1] & en & ~collision, req[0] & en};
    assign rd_acc      = accept & ~is_wr;
    assign wr_acc      = accept & is_wr & in_range;
    assign range_err_d = range_err_q | (accept & ~in_range);

    // NOTE: the RAM array has no reset branch; its contents must survive reset.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (wr_acc[p]) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (be[p][b]) begin
                        mem[addr[p][MEM_AW-1:0]][b*8 +: 8] <= wdata[p][b*8 +: 8];
                    end
                end
            end
        end
    end

    // NOTE: non-blocking assignments make this read see the pre-write word on a same-edge write.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld1_q      <= '0;
            rdata1_q    <= '0;
            range_err_q <= '0;
            s2_prio_q   <= 1'b0;
        end else if (en) begin
            vld1_q      <= rd_acc;
            range_err_q <= range_err_d;
            s2_prio_q   <= collision;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (rd_acc[p]) begin
                    rdata1_q[p] <= in_range[p] ? mem[addr[p][MEM_AW-1:0]] : '0;
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_out_reg
            logic [NUM_PORTS-1:0]                 vld2_q;
            logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata2_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    vld2_q   <= '0;
                    rdata2_q <= '0;
                end else if (en) begin
                    vld2_q   <= vld1_q;
                    rdata2_q <= rdata1_q;
                end
            end

            assign vld_out   = vld2_q;
            assign rdata_out = rdata2_q;
        end else begin : g_no_out_reg
            assign vld_out   = vld1_q;
            assign rdata_out = rdata1_q;
        end
    endgenerate

    assign s1.readdata      = rdata_out[0];
    assign s1.readdatavalid = vld_out[0];
    assign s1.range_err     = range_err_q[0];
    assign s2.readdata      = rdata_out[1];
    assign s2.readdatavalid = vld_out[1];
    assign s2.range_err     = range_err_q[1];
endmodule

// File: tb/tb_onchip_dp_memory.sv
// Self-checking bench for onchip_dp_memory: directed scenarios plus random traffic
// compared every cycle against a behavioural word-array/queue model.
module tb_onchip_dp_memory;
    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int DEPTH = 2500;
    localparam int RL    = 1;

    logic clk = 1'b0;
    logic reset, clken, reset_req;
    always #5 clk = ~clk;

    onchip_dp_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s1_if ();
    onchip_dp_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s2_if ();

    onchip_dp_memory #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .READ_LATENCY(RL), .INIT_FILE("")
    ) dut (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .s1(s1_if), .s2(s2_if)
    );

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: word store, expected-read queues keyed by enabled-edge count.
    typedef struct {
        int          due;
        logic [31:0] data;
        bit          known;
    } exp_t;

    logic [31:0] mem_m [int];
    exp_t        q1 [$];
    exp_t        q2 [$];
    int          en_cnt    = 0;
    bit          stalled_m = 1'b0;
    bit          rerr_m [2] = '{1'b0, 1'b0};

    always @(posedge clk) begin : model
        bit          e, coll;
        bit          rq [2], wr [2], inr [2], acc [2];
        logic [AW-1:0] a [2];
        logic [3:0]  b [2];
        logic [31:0] d [2], old;
        exp_t        item;
        a[0] = s1_if.address;  b[0] = s1_if.byteenable; d[0] = s1_if.writedata;
        a[1] = s2_if.address;  b[1] = s2_if.byteenable; d[1] = s2_if.writedata;
        rq[0] = s1_if.chipselect && (s1_if.read || s1_if.write); wr[0] = s1_if.write;
        rq[1] = s2_if.chipselect && (s2_if.read || s2_if.write); wr[1] = s2_if.write;
        e = clken && !reset_req;
        if (reset) begin
            q1.delete();
            q2.delete();
            rerr_m    = '{1'b0, 1'b0};
            stalled_m = 1'b0;
        end else if (e) begin
            en_cnt++;
            for (int p = 0; p < 2; p++) inr[p] = (a[p] < DEPTH);
            coll = rq[0] && wr[0] && rq[1] && wr[1] && (a[0] == a[1]) && inr[0] && !stalled_m;
            acc[0] = rq[0];
            acc[1] = rq[1] && !coll;
            for (int p = 0; p < 2; p++) begin
                if (acc[p] && !inr[p]) rerr_m[p] = 1'b1;
                if (acc[p] && !wr[p]) begin
                    item.due   = en_cnt + RL - 1;
                    item.data  = !inr[p] ? 32'h0 : (mem_m.exists(int'(a[p])) ? mem_m[int'(a[p])] : 32'hx);
                    item.known = !$isunknown(item.data);
                    if (p == 0) q1.push_back(item); else q2.push_back(item);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (acc[p] && wr[p] && inr[p]) begin
                    old = mem_m.exists(int'(a[p])) ? mem_m[int'(a[p])] : 32'hx;
                    for (int k = 0; k < 4; k++) if (b[p][k]) old[k*8 +: 8] = d[p][k*8 +: 8];
                    mem_m[int'(a[p])] = old;
                end
            end
            stalled_m = coll;
        end
    end

    always @(negedge clk) begin : compare
        bit e, r1, r2, coll, ev1, ev2;
        if (checking) begin
            e  = clken && !reset_req;
            r1 = s1_if.chipselect && (s1_if.read || s1_if.write);
            r2 = s2_if.chipselect && (s2_if.read || s2_if.write);
            coll = e && r1 && s1_if.write && r2 && s2_if.write &&
                   (s1_if.address == s2_if.address) && (s1_if.address < DEPTH) && !stalled_m;
            check("s1_wait", s1_if.waitrequest, !e);
            check("s2_wait", s2_if.waitrequest, !e || coll);
            while (q1.size() > 0 && q1[0].due < en_cnt) void'(q1.pop_front());
            while (q2.size() > 0 && q2[0].due < en_cnt) void'(q2.pop_front());
            ev1 = (q1.size() > 0) && (q1[0].due == en_cnt);
            ev2 = (q2.size() > 0) && (q2[0].due == en_cnt);
            check("s1_valid", s1_if.readdatavalid, ev1);
            check("s2_valid", s2_if.readdatavalid, ev2);
            if (ev1 && s1_if.readdatavalid && q1[0].known) check("s1_rdata", s1_if.readdata, q1[0].data);
            if (ev2 && s2_if.readdatavalid && q2[0].known) check("s2_rdata", s2_if.readdata, q2[0].data);
            check("s1_rerr", s1_if.range_err, rerr_m[0]);
            check("s2_rerr", s2_if.range_err, rerr_m[1]);
        end
    end

    task automatic set_port(input int p, input logic cs, input logic rd, input logic wr,
                            input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] wd);
        if (p == 1) begin
            s1_if.chipselect = cs; s1_if.read = rd; s1_if.write = wr;
            s1_if.address = a; s1_if.byteenable = be; s1_if.writedata = wd;
        end else begin
            s2_if.chipselect = cs; s2_if.read = rd; s2_if.write = wr;
            s2_if.address = a; s2_if.byteenable = be; s2_if.writedata = wd;
        end
    endtask

    task automatic idle_port(input int p);
        set_port(p, 1'b0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic port_valid(input int p);
        return (p == 1) ? s1_if.readdatavalid : s2_if.readdatavalid;
    endfunction

    function automatic logic [31:0] port_rdata(input int p);
        return (p == 1) ? s1_if.readdata : s2_if.readdata;
    endfunction

    task automatic wait_valid(input int p, input string name, output logic [31:0] d, output int lat);
        lat = 0;
        d   = 32'hx;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (port_valid(p)) begin
                lat = i;
                d   = port_rdata(p);
                break;
            end
            step();
        end
        if (lat == 0) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic do_write(input int p, input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] wd);
        set_port(p, 1'b1, 1'b0, 1'b1, a, be, wd);
        step();
        idle_port(p);
    endtask

    task automatic do_read(input int p, input logic [AW-1:0] a, input string name,
                           output logic [31:0] d, output int lat);
        set_port(p, 1'b1, 1'b1, 1'b0, a, 4'h0, 32'h0);
        step();
        idle_port(p);
        wait_valid(p, name, d, lat);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          lat;
        logic [31:0] got [$];
        logic [AW-1:0] fa [9] = '{0, 1, 2, 2, 2, 3, 0, 0, 0};
        bit          frd [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
        bit          fck [9] = '{1, 1, 0, 0, 1, 1, 1, 1, 1};
        bit          prev_ck;

        reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
        idle_port(1); idle_port(2);
        repeat (3) step();
        reset    = 1'b0;
        checking = 1'b1;
        @(negedge clk);
        check("rst_s1_valid", s1_if.readdatavalid, 1'b0);
        check("rst_s2_valid", s2_if.readdatavalid, 1'b0);
        check("rst_s1_rdata", s1_if.readdata, 32'h0);
        check("rst_s2_rdata", s2_if.readdata, 32'h0);
        check("rst_s1_rerr", s1_if.range_err, 1'b0);
        check("rst_s2_rerr", s2_if.range_err, 1'b0);
        step();

        for (int i = 0; i < 16; i++) do_write(2, AW'(i), 4'hF, 32'h100 + 32'(i));

        // Basic write then read on both ports
        do_write(1, 12'd5, 4'hF, 32'hDEADBEEF);
        do_read(1, 12'd5, "basic_s1", d, lat);
        check("basic_s1_data", d, 32'hDEADBEEF);
        check("basic_s1_lat", 64'(lat), 64'(RL));
        do_read(2, 12'd5, "basic_s2", d, lat);
        check("basic_s2_data", d, 32'hDEADBEEF);

        // Byte enables
        do_write(1, 12'd9, 4'hF, 32'hFFFFFFFF);
        do_write(1, 12'd9, 4'h5, 32'h12345678);
        check("pin_model_m9", mem_m[9], 32'hFF34FF78);
        do_read(2, 12'd9, "byteen", d, lat);
        check("byteen_data", d, 32'hFF34FF78);

        // Same-address write collision
        set_port(1, 1'b1, 1'b0, 1'b1, 12'd100, 4'hF, 32'h11111111);
        set_port(2, 1'b1, 1'b0, 1'b1, 12'd100, 4'hF, 32'h22222222);
        #2;
        check("coll_s2_wait_c0", s2_if.waitrequest, 1'b1);
        check("coll_s1_wait_c0", s1_if.waitrequest, 1'b0);
        step();
        idle_port(1);
        #2;
        check("coll_s2_wait_c1", s2_if.waitrequest, 1'b0);
        step();
        idle_port(2);
        check("pin_model_m100", mem_m[100], 32'h22222222);
        do_read(1, 12'd100, "coll", d, lat);
        check("coll_data", d, 32'h22222222);

        // Cross-port read-during-write returns the old word
        do_write(1, 12'd7, 4'hF, 32'hA);
        set_port(1, 1'b1, 1'b0, 1'b1, 12'd7, 4'hF, 32'hB);
        set_port(2, 1'b1, 1'b1, 1'b0, 12'd7, 4'h0, 32'h0);
        step();
        idle_port(1); idle_port(2);
        wait_valid(2, "rdw_old", d, lat);
        check("rdw_old_data", d, 32'hA);
        step();
        do_read(2, 12'd7, "rdw_new", d, lat);
        check("rdw_new_data", d, 32'hB);

        // Streamed reads with a two-cycle clken freeze
        step();
        prev_ck = 1'b1;
        for (int i = 0; i < 9; i++) begin
            set_port(2, frd[i], frd[i], 1'b0, fa[i], 4'h0, 32'h0);
            clken = fck[i];
            @(negedge clk);
            if (!fck[i]) check("frz_wait", s2_if.waitrequest, 1'b1);
            if (prev_ck && s2_if.readdatavalid) got.push_back(s2_if.readdata);
            prev_ck = fck[i];
            step();
        end
        idle_port(2);
        clken = 1'b1;
        check("frz_count", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("frz_order", got[i], 32'h100 + 32'(i));

        // Out-of-range access
        do_write(1, 12'd2600, 4'hF, 32'h55);
        @(negedge clk);
        check("oor_s1_rerr", s1_if.range_err, 1'b1);
        check("oor_s2_rerr", s2_if.range_err, 1'b0);
        check("pin_model_oor", 64'(mem_m.exists(2600)), 64'd0);
        step();
        do_read(1, 12'd2600, "oor_rd", d, lat);
        check("oor_rd_data", d, 32'h0);
        step();

        // Reset while a read is in flight
        set_port(1, 1'b1, 1'b1, 1'b0, 12'd5, 4'h0, 32'h0);
        reset = 1'b1;
        step();
        idle_port(1);
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_inflight_valid", s1_if.readdatavalid, 1'b0);
            step();
        end
        check("rst_rerr_clear", s1_if.range_err, 1'b0);
        do_read(1, 12'd5, "rst_keep", d, lat);
        check("rst_keep_data", d, 32'hDEADBEEF);
        step();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int p = 1; p <= 2; p++) begin
                int unsigned r;
                logic [AW-1:0] a;
                r = $urandom_range(0, 99);
                a = ($urandom_range(0, 7) == 0) ? AW'(2500 + $urandom_range(0, 3)) : AW'($urandom_range(0, 15));
                if (r < 30)      idle_port(p);
                else if (r < 65) set_port(p, 1'b1, 1'b1, 1'b0, a, 4'($urandom), $urandom);
                else             set_port(p, 1'b1, ($urandom_range(0, 9) == 0), 1'b1, a, 4'($urandom), $urandom);
            end
            if (s1_if.write && $urandom_range(0, 5) == 0) begin
                set_port(2, 1'b1, 1'b0, 1'b1, s1_if.address, 4'($urandom), $urandom);
            end
            clken     = ($urandom_range(0, 9) != 0);
            reset_req = ($urandom_range(0, 19) == 0);
            step();
        end
        idle_port(1); idle_port(2);
        clken = 1'b1; reset_req = 1'b0;
        repeat (6) step();
        check("drain_q1", 64'(q1.size()), 64'd0);
        check("drain_q2", 64'(q2.size()), 64'd0);

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/onchip_dp_memory.md
# onchip_dp_memory

Parametrised dual-port on-chip RAM with two independent Avalon-MM slaves (s1, s2), configurable data width, depth, read latency and init file. It extends the single-port on-chip memory used in the wifiSystem Qsys design with a second port, pipelined reads with `readdatavalid`, and deterministic write-collision arbitration. It sits beside the Nios II, giving instruction/data or CPU/DMA masters concurrent access.

## Interface
- `DATA_WIDTH`, 32: word width; multiple of 8.
- `ADDR_WIDTH`, 12: word-address width.
- `DEPTH`, 2500: words implemented, ≤ 2^ADDR_WIDTH.
- `READ_LATENCY`, 1: 1 or 2 cycles from read accept to `readdatavalid`; 2 adds an output register.
- `INIT_FILE`, "onchip_dp_memory.hex": initial contents; "" leaves RAM uninitialised.
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `clken` in 1: global clock enable.
- `reset_req` in 1: high freezes the block like `clken`=0.
- `sN_address` in ADDR_WIDTH: word address (N = 1, 2).
- `sN_byteenable` in DATA_WIDTH/8: per-byte write enable.
- `sN_chipselect`, `sN_read`, `sN_write` in 1 each: Avalon request qualifiers.
- `sN_writedata` in DATA_WIDTH: write data.
- `sN_readdata` out DATA_WIDTH: read data, meaningful only with `readdatavalid`.
- `sN_readdatavalid` out 1: one-cycle pulse per accepted read.
- `sN_waitrequest` out 1: request not accepted this cycle.
- `sN_range_err` out 1: sticky; set on any access with address ≥ DEPTH; cleared only by `reset`.

## Operation
- Effective enable `en` = `clken` & ~`reset_req`. With `en`=0, nothing is accepted: both `waitrequest` high, RAM and pipeline frozen, outputs hold.
- Request on port N = `chipselect` & (`read` | `write`). `read` and `write` high together is treated as a write.
- Accept: request & ~`waitrequest` & `en`.
- Write: bytes with `byteenable` set are updated at the accepting edge; other bytes keep their value.
- Read: address is sampled at accept. Data returns after READ_LATENCY cycles with a one-cycle `readdatavalid`. One read can be accepted per cycle per port (fully pipelined).
- Out-of-range address (≥ DEPTH): writes are dropped; reads complete normally and return all zeros; `range_err` is set.
- Collision: both ports write the same in-range address in the same cycle. s1 is accepted. `s2_waitrequest`=1 that cycle. s2 is accepted on the next cycle, so s2's data overwrites s1 at the bytes s2 enables.
- Read/write same address in the same cycle (same port or cross-port): the read returns the old data (pre-write). No stall.
- `waitrequest` is otherwise 0. It is combinational from the current requests and `en`.
- Reset:
  - All `readdata` = 0, all `readdatavalid` = 0, `range_err` = 0, pipeline valid bits cleared.
  - RAM contents are preserved.
  - Reads in flight when `reset` asserts are discarded and never signalled.

## Timing
- READ_LATENCY=1: read accepted at edge k, so `readdata`/`readdatavalid` are valid after edge k+1 (registered RAM output).
- READ_LATENCY=2: valid after edge k+2.
- When `en`=0, the pipeline stalls. An outstanding `readdatavalid` stays asserted (held) until `en` returns, then completes on the next enabled edge.
- Write visible to a read accepted on the cycle after the write.
- Collision stall costs s2 exactly one cycle, assuming s2 holds its request per Avalon rules.
- `range_err` is set on the accepting edge.

## Test plan
- Reset, then s1 write 0xDEADBEEF to addr 5 with byteenable 0xF, then s1 read addr 5 → `s1_readdatavalid` 1 cycle later (2 with READ_LATENCY=2), `s1_readdata`=0xDEADBEEF. s2 read addr 5 returns the same value.
- Byte enables: write 0xFFFFFFFF to addr 9, then write 0x12345678 with byteenable 0x5 → read returns 0xFF34FF78.
- Collision: s1 writes 0x11111111 and s2 writes 0x22222222 to addr 100 in the same cycle → `s2_waitrequest`=1 for exactly 1 cycle; final read of addr 100 = 0x22222222.
- Cross-port RDW: addr 7 = 0xA; s1 writes 0xB while s2 reads addr 7 in the same cycle → s2 gets 0xA; next s2 read gets 0xB.
- Back-to-back reads of addr 0..3 on s2 every cycle, with `clken` low for 2 cycles mid-stream → 4 valid pulses in order, no loss or duplication, waitrequest high during the freeze.
- Write 0x55 to addr 2600 (DEPTH=2500) → `s1_range_err`=1, RAM unchanged, read of addr 2600 returns 0. Assert `reset` during an outstanding read → no `readdatavalid`; `range_err` clears; RAM data survives.
